// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
//
// Contents:
//   Def*       default values for the debounce_multi / debounce_channel parameters
//   cnt_width  number of bits needed to hold a counter value (never less than 1)
//   max_u      larger of two unsigned values, used to size the repeat counter
package debounce_pkg;

   localparam int unsigned DefNCh         = 4;
   localparam int unsigned DefSyncStages  = 2;
   localparam int unsigned DefStableCnt   = 8;
   localparam int unsigned DefRepeatDelay = 20;
   localparam int unsigned DefRepeatRate  = 5;

   // Bits needed to represent max_val; a counter that only ever holds 0 still needs one bit.
   // cnt_width(n - 1) equals clog2(n) for n >= 2, which is how the stability counter is sized.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: synchroniser, stability counter, edge pulses and auto-repeat.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset, clears all state and outputs
//   button         raw asynchronous button input
//   repeat_en      auto-repeat enable, sampled every cycle
//   level          debounced button level
//   press_pulse    high for the first cycle level reads 1
//   release_pulse  high for the first cycle level reads 0
//   repeat_pulse   one-cycle auto-repeat strobe while the button is held
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = DefSyncStages,
   parameter int unsigned STABLE_CNT   = DefStableCnt,
   parameter int unsigned REPEAT_DELAY = DefRepeatDelay,
   parameter int unsigned REPEAT_RATE  = DefRepeatRate
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   input  logic repeat_en,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int unsigned StableW = cnt_width(STABLE_CNT - 1);
   localparam int unsigned RepeatW = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));

   localparam logic [StableW-1:0] StableLast   = StableW'(STABLE_CNT - 1);
   localparam logic [StableW-1:0] StableOne    = StableW'(1);
   localparam logic [RepeatW-1:0] RepeatLoad   = RepeatW'(REPEAT_DELAY);
   localparam logic [RepeatW-1:0] RepeatReload = RepeatW'(REPEAT_RATE);
   localparam logic [RepeatW-1:0] RepeatOne    = RepeatW'(1);
   localparam bit                 RepeatOn     = (REPEAT_DELAY != 0);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sample;

   logic [StableW-1:0]     stable_q, stable_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;

   logic [RepeatW-1:0]     rep_cnt_q, rep_cnt_d;
   logic                   rep_q, rep_d;

   // Synchroniser: bit 0 takes the raw input, the top bit is the sample seen by the counter.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], button};
   end

   assign sample = sync_q[SYNC_STAGES-1];

   // Stability counter: any sample matching the level restarts the count, so a glitch
   // shorter than STABLE_CNT samples never reaches the level.
   always_comb begin
      stable_d = '0;
      level_d  = level_q;
      if (sample != level_q) begin
         if (stable_q == StableLast) begin
            level_d = sample;
         end else begin
            stable_d = stable_q + StableOne;
         end
      end
   end

   // Pulses are registered alongside the level so they line up with its first new cycle.
   always_comb begin
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
   end

   // Auto-repeat down-counter. Loaded with the delay on the press edge, reloaded with the
   // rate on every strobe, frozen while repeat_en is low, cleared whenever not held.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      rep_d     = 1'b0;
      if (!RepeatOn || !level_d) begin
         rep_cnt_d = '0;
      end else if (!level_q) begin
         rep_cnt_d = RepeatLoad;
      end else if (repeat_en) begin
         if (rep_cnt_q == RepeatOne) begin
            rep_d     = 1'b1;
            rep_cnt_d = RepeatReload;
         end else begin
            rep_cnt_d = rep_cnt_q - RepeatOne;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         stable_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         rep_cnt_q <= '0;
         rep_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         stable_q  <= stable_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         rep_cnt_q <= rep_cnt_d;
         rep_q     <= rep_d;
      end
   end

   assign level         = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign repeat_pulse  = rep_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer with press/release pulses and auto-repeat.
// Each channel is an independent debounce_channel; this level holds no state of its own.
//
// Ports:
//   debounceClk     single rising-edge clock
//   rstN            asynchronous active-low reset
//   button          raw asynchronous button inputs, bit i is channel i
//   repeatEn        global auto-repeat enable, sampled every cycle
//   debounceButton  debounced level per channel
//   pressPulse      one-cycle pulse on each debounced rising level
//   releasePulse    one-cycle pulse on each debounced falling level
//   repeatPulse     one-cycle auto-repeat pulse while a channel is held
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH         = DefNCh,
   parameter int unsigned SYNC_STAGES  = DefSyncStages,
   parameter int unsigned STABLE_CNT   = DefStableCnt,
   parameter int unsigned REPEAT_DELAY = DefRepeatDelay,
   parameter int unsigned REPEAT_RATE  = DefRepeatRate
) (
   input  logic            debounceClk,
   input  logic            rstN,
   input  logic [N_CH-1:0] button,
   input  logic            repeatEn,
   output logic [N_CH-1:0] debounceButton,
   output logic [N_CH-1:0] pressPulse,
   output logic [N_CH-1:0] releasePulse,
   output logic [N_CH-1:0] repeatPulse
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CNT   (STABLE_CNT),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_channel (
         .clk           (debounceClk),
         .rst_n         (rstN),
         .button        (button[i]),
         .repeat_en     (repeatEn),
         .level         (debounceButton[i]),
         .press_pulse   (pressPulse[i]),
         .release_pulse (releasePulse[i]),
         .repeat_pulse  (repeatPulse[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (4 channels, 2 sync stages, 8 stable samples,
// repeat delay 20, repeat rate 5). Directed scenarios use edge numbers worked out from the
// behaviour; the random scenario uses a sample-history model of the debouncer.
module tb_debounce_multi;

   localparam int NCh    = 4;
   localparam int Sync   = 2;
   localparam int Stable = 8;
   localparam int Delay  = 20;
   localparam int Rate   = 5;
   localparam int Lat    = Sync + Stable;
   localparam int NCyc   = 1500;

   logic           clk;
   logic           rst_n;
   logic [NCh-1:0] button;
   logic           repeat_en;
   logic [NCh-1:0] deb;
   logic [NCh-1:0] press;
   logic [NCh-1:0] rel;
   logic [NCh-1:0] rep;

   int n_cmp;
   int n_fail;

   // Model storage for the random scenario: raw input and enable seen at each edge.
   logic [NCh-1:0] raw_hist [0:NCyc];
   logic           en_hist  [0:NCyc];

   debounce_multi #(
      .N_CH         (NCh),
      .SYNC_STAGES  (Sync),
      .STABLE_CNT   (Stable),
      .REPEAT_DELAY (Delay),
      .REPEAT_RATE  (Rate)
   ) dut (
      .debounceClk    (clk),
      .rstN           (rst_n),
      .button         (button),
      .repeatEn       (repeat_en),
      .debounceButton (deb),
      .pressPulse     (press),
      .releasePulse   (rel),
      .repeatPulse    (rep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reset with inputs idle; returns just after edge 0, the last edge seen in reset.
   task automatic do_reset();
      rst_n     = 1'b0;
      button    = '0;
      repeat_en = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      button    = 4'($urandom);
      repeat_en = 1'b1;
      repeat (4) cyc();
      n_cmp++; if (deb !== '0) begin n_fail++; $display("FAIL reset_level: got %b want 0000", deb); end
      n_cmp++; if (press !== '0) begin n_fail++; $display("FAIL reset_press: got %b want 0000", press); end
      n_cmp++; if (rel !== '0) begin n_fail++; $display("FAIL reset_release: got %b want 0000", rel); end
      n_cmp++; if (rep !== '0) begin n_fail++; $display("FAIL reset_repeat: got %b want 0000", rep); end
   endtask

   task automatic test_clean_press();
      logic [NCh-1:0] e_deb, e_press, e_rel;
      do_reset();
      repeat_en = 1'b1;
      button    = 4'b0001;
      for (int n = 1; n <= Lat + 3; n++) begin
         cyc();
         e_deb   = (n >= Lat) ? 4'b0001 : 4'b0000;
         e_press = (n == Lat) ? 4'b0001 : 4'b0000;
         n_cmp++; if (deb !== e_deb) begin n_fail++; $display("FAIL clean_press_level edge %0d: got %b want %b", n, deb, e_deb); end
         n_cmp++; if (press !== e_press) begin n_fail++; $display("FAIL clean_press_pulse edge %0d: got %b want %b", n, press, e_press); end
      end
      button = 4'b0000;
      for (int n = 1; n <= Lat + 2; n++) begin
         cyc();
         e_deb = (n >= Lat) ? 4'b0000 : 4'b0001;
         e_rel = (n == Lat) ? 4'b0001 : 4'b0000;
         n_cmp++; if (deb !== e_deb) begin n_fail++; $display("FAIL clean_release_level edge %0d: got %b want %b", n, deb, e_deb); end
         n_cmp++; if (rel !== e_rel) begin n_fail++; $display("FAIL clean_release_pulse edge %0d: got %b want %b", n, rel, e_rel); end
      end
   endtask

   task automatic test_glitch();
      logic [NCh-1:0] e_deb, e_press, e_rel;
      do_reset();
      button = 4'b0010;
      repeat (Stable - 1) cyc();
      button = 4'b0000;
      for (int n = 1; n <= 20; n++) begin
         cyc();
         n_cmp++; if ({deb, press, rel, rep} !== '0) begin n_fail++; $display("FAIL glitch_quiet edge %0d: got %b/%b/%b/%b want all 0", n, deb, press, rel, rep); end
      end
      button = 4'b0010;
      for (int n = 1; n <= 20; n++) begin
         cyc();
         e_deb   = (n >= Lat && n < Lat + Stable) ? 4'b0010 : 4'b0000;
         e_press = (n == Lat) ? 4'b0010 : 4'b0000;
         e_rel   = (n == Lat + Stable) ? 4'b0010 : 4'b0000;
         n_cmp++; if (deb !== e_deb) begin n_fail++; $display("FAIL glitch8_level edge %0d: got %b want %b", n, deb, e_deb); end
         n_cmp++; if (press !== e_press) begin n_fail++; $display("FAIL glitch8_press edge %0d: got %b want %b", n, press, e_press); end
         n_cmp++; if (rel !== e_rel) begin n_fail++; $display("FAIL glitch8_release edge %0d: got %b want %b", n, rel, e_rel); end
         if (n == Stable) button = 4'b0000;
      end
   endtask

   task automatic test_auto_repeat();
      logic [NCh-1:0] e_press, e_rel, e_rep;
      do_reset();
      repeat_en = 1'b1;
      button    = 4'b0100;
      for (int n = 1; n <= 75; n++) begin
         cyc();
         e_press = (n == 10) ? 4'b0100 : 4'b0000;
         e_rel   = (n == 70) ? 4'b0100 : 4'b0000;
         e_rep   = (n >= 30 && n <= 65 && (n - 30) % 5 == 0) ? 4'b0100 : 4'b0000;
         n_cmp++; if (press !== e_press) begin n_fail++; $display("FAIL repeat_press edge %0d: got %b want %b", n, press, e_press); end
         n_cmp++; if (rel !== e_rel) begin n_fail++; $display("FAIL repeat_release edge %0d: got %b want %b", n, rel, e_rel); end
         n_cmp++; if (rep !== e_rep) begin n_fail++; $display("FAIL repeat_pulse edge %0d: got %b want %b", n, rep, e_rep); end
         if (n == 60) button = 4'b0000;
      end
   endtask

   task automatic test_repeat_gate();
      logic [NCh-1:0] e_rep, e_rel;
      do_reset();
      repeat_en = 1'b1;
      button    = 4'b0100;
      for (int n = 1; n <= 70; n++) begin
         cyc();
         e_rep = (n == 30 || n == 35 || (n >= 47 && n <= 62 && (n - 47) % 5 == 0)) ? 4'b0100 : 4'b0000;
         e_rel = (n == 65) ? 4'b0100 : 4'b0000;
         n_cmp++; if (rep !== e_rep) begin n_fail++; $display("FAIL gate_repeat edge %0d: got %b want %b", n, rep, e_rep); end
         n_cmp++; if (rel !== e_rel) begin n_fail++; $display("FAIL gate_release edge %0d: got %b want %b", n, rel, e_rel); end
         if (n == 36) repeat_en = 1'b0;
         if (n == 43) repeat_en = 1'b1;
         if (n == 55) button = 4'b0000;
      end
   endtask

   task automatic test_simultaneous();
      logic [NCh-1:0] e_press, e_rel;
      do_reset();
      button = 4'b1111;
      for (int n = 1; n <= 24; n++) begin
         cyc();
         e_press = (n == 10) ? 4'b1111 : 4'b0000;
         e_rel   = (n == 22) ? 4'b1111 : 4'b0000;
         n_cmp++; if (press !== e_press) begin n_fail++; $display("FAIL simul_press edge %0d: got %b want %b", n, press, e_press); end
         n_cmp++; if (rel !== e_rel) begin n_fail++; $display("FAIL simul_release edge %0d: got %b want %b", n, rel, e_rel); end
         if (n == 12) button = 4'b0000;
      end
   endtask

   task automatic test_async_reset();
      logic [NCh-1:0] e_deb, e_press;
      do_reset();
      repeat_en = 1'b1;
      button    = 4'b1000;
      repeat (35) cyc();
      n_cmp++; if (rep !== 4'b1000) begin n_fail++; $display("FAIL areset_pre_repeat: got %b want 1000", rep); end
      n_cmp++; if (deb !== 4'b1000) begin n_fail++; $display("FAIL areset_pre_level: got %b want 1000", deb); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({deb, press, rel, rep} !== '0) begin n_fail++; $display("FAIL areset_immediate: got %b/%b/%b/%b want all 0", deb, press, rel, rep); end
      for (int n = 1; n <= 3; n++) begin
         cyc();
         n_cmp++; if ({deb, press, rel, rep} !== '0) begin n_fail++; $display("FAIL areset_held edge %0d: got %b/%b/%b/%b want all 0", n, deb, press, rel, rep); end
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         cyc();
         e_deb   = (n >= Lat) ? 4'b1000 : 4'b0000;
         e_press = (n == Lat) ? 4'b1000 : 4'b0000;
         n_cmp++; if (deb !== e_deb) begin n_fail++; $display("FAIL areset_after_level edge %0d: got %b want %b", n, deb, e_deb); end
         n_cmp++; if (press !== e_press) begin n_fail++; $display("FAIL areset_after_press edge %0d: got %b want %b", n, press, e_press); end
         n_cmp++; if (rel !== '0) begin n_fail++; $display("FAIL areset_after_release edge %0d: got %b want 0000", n, rel); end
      end
   endtask

   // Random segments per channel; model: the level flips at an edge when the previous Stable
   // synchronised samples all disagree with it; repeats fall on the Delay-th enabled held edge
   // after the press and every Rate-th enabled held edge after that.
   task automatic test_random();
      logic [NCh-1:0] lvl, new_lvl, e_press, e_rel, e_rep;
      int             seg_left [NCh];
      int             held_en  [NCh];
      logic           stable, smp;
      int             idx;
      do_reset();
      lvl         = '0;
      raw_hist[0] = '0;
      en_hist[0]  = 1'b0;
      for (int c = 0; c < NCh; c++) begin
         seg_left[c] = 0;
         held_en[c]  = 0;
      end
      for (int k = 1; k <= NCyc; k++) begin
         for (int c = 0; c < NCh; c++) begin
            if (seg_left[c] == 0) begin
               button[c]   = ~button[c];
               seg_left[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9))
                                                         : int'($urandom_range(8, 60));
            end
            seg_left[c]--;
         end
         if ($urandom_range(0, 19) == 0) repeat_en = ~repeat_en;
         raw_hist[k] = button;
         en_hist[k]  = repeat_en;
         cyc();
         for (int c = 0; c < NCh; c++) begin
            stable = 1'b1;
            for (int j = 0; j < Stable; j++) begin
               idx = k - j;
               smp = (idx - Sync >= 1) ? raw_hist[idx - Sync][c] : 1'b0;
               if (idx < 1 || smp == lvl[c]) stable = 1'b0;
            end
            new_lvl[c] = stable ? ~lvl[c] : lvl[c];
            e_press[c] = new_lvl[c] & ~lvl[c];
            e_rel[c]   = ~new_lvl[c] & lvl[c];
            e_rep[c]   = 1'b0;
            if (e_press[c]) begin
               held_en[c] = 0;
            end else if (new_lvl[c] && lvl[c] && en_hist[k]) begin
               held_en[c]++;
               if (held_en[c] >= Delay && (held_en[c] - Delay) % Rate == 0) e_rep[c] = 1'b1;
            end
         end
         lvl = new_lvl;
         n_cmp++; if (deb !== lvl) begin n_fail++; $display("FAIL rand_level edge %0d: got %b want %b", k, deb, lvl); end
         n_cmp++; if (press !== e_press) begin n_fail++; $display("FAIL rand_press edge %0d: got %b want %b", k, press, e_press); end
         n_cmp++; if (rel !== e_rel) begin n_fail++; $display("FAIL rand_release edge %0d: got %b want %b", k, rel, e_rel); end
         n_cmp++; if (rep !== e_rep) begin n_fail++; $display("FAIL rand_repeat edge %0d: got %b want %b", k, rep, e_rep); end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      button    = '0;
      repeat_en = 1'b0;
      test_reset();
      test_clean_press();
      test_glitch();
      test_auto_repeat();
      test_repeat_gate();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, 2..4.
REQ-003 Parameter STABLE_CNT, default 8: consecutive identical samples required to change a debounced level, 2..65535.
REQ-004 Parameter REPEAT_DELAY, default 20: cycles from press to first auto-repeat pulse; 0 disables auto-repeat.
REQ-005 Parameter REPEAT_RATE, default 5: cycles between subsequent auto-repeat pulses, at least 1.
REQ-006 debounceClk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rstN  in  1  reset, asynchronous and active-low.
REQ-008 button  in  N_CH  raw asynchronous button inputs, bit i is channel i.
REQ-009 repeatEn  in  1  global auto-repeat enable, sampled every cycle.
REQ-010 debounceButton  out  N_CH  debounced level per channel.
REQ-011 pressPulse  out  N_CH  one-cycle pulse on each debounced rising level.
REQ-012 releasePulse  out  N_CH  one-cycle pulse on each debounced falling level.
REQ-013 repeatPulse  out  N_CH  one-cycle auto-repeat pulse while a channel is held.

Function
REQ-014 Each channel SHALL pass button[i] through a SYNC_STAGES-deep flip-flop chain; the last stage is the sample.
REQ-015 Each channel SHALL keep a stability counter of width clog2(STABLE_CNT): clear when sample equals the level, increment when it differs.
REQ-016 On a cycle where sample differs from the level and the counter equals STABLE_CNT-1, the level SHALL take the sample value and the counter SHALL clear.
REQ-017 Any sample equal to the level before the threshold SHALL clear the counter, so a glitch restarts the count; the level never changes.
REQ-018 Latency: after a clean input edge, debounceButton[i] SHALL change exactly SYNC_STAGES+STABLE_CNT clock edges later.
REQ-019 pressPulse[i] SHALL be high for exactly the one cycle in which debounceButton[i] first reads 1; releasePulse[i] likewise on the first cycle at 0.
REQ-020 Per channel, a repeat counter (width fits max(REPEAT_DELAY, REPEAT_RATE)) SHALL load at press and count while the level is 1 and repeatEn is 1.
REQ-021 First repeatPulse[i] SHALL occur REPEAT_DELAY cycles after the pressPulse[i] cycle; later pulses SHALL occur every REPEAT_RATE cycles until release.
REQ-022 If repeatEn is 0, the repeat counter SHALL hold and repeatPulse SHALL stay 0; when repeatEn returns to 1, counting resumes from the held value.
REQ-023 On release, or if REPEAT_DELAY is 0, repeatPulse[i] SHALL be 0 and the repeat counter SHALL clear; pressPulse and repeatPulse never assert in the same cycle.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-025 While rstN=0, all synchroniser stages, counters, debounceButton, pressPulse, releasePulse and repeatPulse SHALL be 0 immediately, independent of the clock.
REQ-026 After rstN rises, a button already held SHALL produce a normal pressPulse after SYNC_STAGES+STABLE_CNT cycles.
REQ-027 Reset asserted mid-count or mid-repeat SHALL abort without any pulse, and no releasePulse SHALL be generated by reset.

Structure
REQ-028 Package debounce_pkg SHALL hold the default parameter constants and a clog2-based width function used for counter sizing.
REQ-029 Per-channel logic SHALL be a sub-module debounce_channel, instantiated N_CH times in a generate loop; the top contains no other state.

Verification (N_CH=4, SYNC_STAGES=2, STABLE_CNT=8, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-030 Clean press: button[0] 0->1 at edge 0 and held -> debounceButton[0]=1 and pressPulse[0] high for one cycle at edge 10, other channels stay 0.
REQ-031 Glitch: button[1] high for 7 cycles then low -> debounceButton[1] and all pulses on channel 1 stay 0; a high of 8 cycles gives a press.
REQ-032 Auto-repeat: hold button[2] 60 cycles with repeatEn=1 -> repeatPulse[2] at 20, 25, 30... cycles after pressPulse, then one releasePulse 10 edges after the input falls.
REQ-033 repeatEn gating: drop repeatEn for 7 cycles mid-hold -> no repeat pulses during the gap, next pulse delayed by exactly 7 cycles.
REQ-034 Simultaneous: all 4 buttons rise on the same edge -> pressPulse=4'b1111 in one cycle.
REQ-035 Async reset: assert rstN=0 between clock edges during repeat -> all outputs 0 at once; deassert with button held -> fresh pressPulse after 10 edges.
